// File: rtl/p03_clock_pkg.sv
// Shared constants for the BCD time-of-day counter: digit width, field limits,
// reset times and a helper that splits a binary field value into two BCD digits.
package p03_clock_pkg;

  localparam int BCD_W = 4;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HRS_MAX_24 = 23;
  localparam int HRS_MAX_12 = 12;
  localparam int HRS_MIN_12 = 1;
  localparam int FIELD_MIN  = 0;

  localparam int SEC_RESET    = 0;
  localparam int MIN_RESET    = 0;
  localparam int HRS_RESET_24 = 0;
  localparam int HRS_RESET_12 = 12;

  typedef struct packed {
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } bcd_pair_t;

  function automatic bcd_pair_t to_bcd_pair(input int unsigned value);
    bcd_pair_t pair;
    pair.d1 = BCD_W'(value / 10);
    pair.d0 = BCD_W'(value % 10);
    return pair;
  endfunction

endpackage

// File: rtl/p03_bcd_digit_pair.sv
// Two-digit BCD counter running MIN_VAL..MAX_VAL. wrap flags the increment that
// takes the value from MAX_VAL back to MIN_VAL so the caller can build a carry.
module p03_bcd_digit_pair
  import p03_clock_pkg::*;
#(
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 59,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0,
  output logic             wrap
);

  localparam bcd_pair_t MIN_BCD   = to_bcd_pair(MIN_VAL);
  localparam bcd_pair_t MAX_BCD   = to_bcd_pair(MAX_VAL);
  localparam bcd_pair_t RESET_BCD = to_bcd_pair(RESET_VAL);

  bcd_pair_t value_reg;
  bcd_pair_t value_next;
  logic      at_max;

  assign at_max = (value_reg == MAX_BCD);
  assign wrap   = inc & at_max;

  always_comb begin
    value_next = value_reg;
    if (inc) begin
      if (at_max) begin
        value_next = MIN_BCD;
      end else if (value_reg.d0 == BCD_W'(9)) begin
        value_next.d0 = '0;
        value_next.d1 = value_reg.d1 + BCD_W'(1);
      end else begin
        value_next.d0 = value_reg.d0 + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= RESET_BCD;
    end else begin
      value_reg <= value_next;
    end
  end

  assign d1 = value_reg.d1;
  assign d0 = value_reg.d0;

endmodule

// File: rtl/p03_bcd_time_counter.sv
// HH:MM:SS wall-clock counter in BCD. The 1 Hz tick ripples seconds->minutes->hours;
// set pulses bump a single field with no carry and take priority over the tick.
module p03_bcd_time_counter
  import p03_clock_pkg::*;
#(
  parameter int HOURS_24 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             sec_tick,
  input  logic             adj_hrs,
  input  logic             adj_min,
  input  logic             adj_sec,
  output logic [BCD_W-1:0] hrs_d1,
  output logic [BCD_W-1:0] hrs_d0,
  output logic [BCD_W-1:0] min_d1,
  output logic [BCD_W-1:0] min_d0,
  output logic [BCD_W-1:0] sec_d1,
  output logic [BCD_W-1:0] sec_d0,
  output logic             min_rollover
);

  localparam int HRS_LO    = (HOURS_24 != 0) ? FIELD_MIN    : HRS_MIN_12;
  localparam int HRS_HI    = (HOURS_24 != 0) ? HRS_MAX_24   : HRS_MAX_12;
  localparam int HRS_RESET = (HOURS_24 != 0) ? HRS_RESET_24 : HRS_RESET_12;

  logic any_adj;
  logic tick_qual;
  logic sec_inc;
  logic sec_wrap;
  logic sec_carry;
  logic min_inc;
  logic min_wrap;
  logic min_carry;
  logic hrs_inc;
  logic day_wrap_unused;
  logic min_rollover_reg;

  // A set pulse in the same cycle swallows the tick entirely.
  assign any_adj   = adj_hrs | adj_min | adj_sec;
  assign tick_qual = clk_en & sec_tick & ~any_adj;

  assign sec_inc   = (clk_en & adj_sec) | tick_qual;
  assign sec_carry = sec_wrap & tick_qual;
  assign min_inc   = (clk_en & adj_min) | sec_carry;
  assign min_carry = min_wrap & sec_carry;
  assign hrs_inc   = (clk_en & adj_hrs) | min_carry;

  p03_bcd_digit_pair #(
    .MIN_VAL   (FIELD_MIN),
    .MAX_VAL   (SEC_MAX),
    .RESET_VAL (SEC_RESET)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .d1    (sec_d1),
    .d0    (sec_d0),
    .wrap  (sec_wrap)
  );

  p03_bcd_digit_pair #(
    .MIN_VAL   (FIELD_MIN),
    .MAX_VAL   (MIN_MAX),
    .RESET_VAL (MIN_RESET)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .d1    (min_d1),
    .d0    (min_d0),
    .wrap  (min_wrap)
  );

  // Hours are the last field; their wrap has nothing downstream to feed.
  p03_bcd_digit_pair #(
    .MIN_VAL   (HRS_LO),
    .MAX_VAL   (HRS_HI),
    .RESET_VAL (HRS_RESET)
  ) u_hrs (
    .clk   (clk),
    .reset (reset),
    .inc   (hrs_inc),
    .d1    (hrs_d1),
    .d0    (hrs_d0),
    .wrap  (day_wrap_unused)
  );

  // Strobes when a tick-driven seconds wrap starts a new minute.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_rollover_reg <= 1'b0;
    end else begin
      min_rollover_reg <= sec_carry;
    end
  end

  assign min_rollover = min_rollover_reg;

endmodule

// File: tb/tb_p03_bcd_time_counter.sv
// Bench for the BCD time counter: a 24h and a 12h instance share stimulus and are
// checked against a plain-integer time-of-day model, plus directed scenarios.
module tb_p03_bcd_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic sec_tick = 1'b0;
  logic adj_hrs = 1'b0;
  logic adj_min = 1'b0;
  logic adj_sec = 1'b0;

  logic [3:0] a_h1, a_h0, a_m1, a_m0, a_s1, a_s0;
  logic [3:0] b_h1, b_h0, b_m1, b_m0, b_s1, b_s0;
  logic       a_ro, b_ro;
  logic [24:0] obs24, obs12;

  int mh[2];
  int mm[2];
  int ms[2];
  bit mro[2];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  p03_bcd_time_counter #(.HOURS_24(1)) dut24 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sec_tick(sec_tick),
    .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .hrs_d1(a_h1), .hrs_d0(a_h0), .min_d1(a_m1), .min_d0(a_m0),
    .sec_d1(a_s1), .sec_d0(a_s0), .min_rollover(a_ro)
  );

  p03_bcd_time_counter #(.HOURS_24(0)) dut12 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sec_tick(sec_tick),
    .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .hrs_d1(b_h1), .hrs_d0(b_h0), .min_d1(b_m1), .min_d0(b_m0),
    .sec_d1(b_s1), .sec_d0(b_s0), .min_rollover(b_ro)
  );

  // Displayed in hex this reads as R HHMMSS (R = min_rollover).
  assign obs24 = {a_ro, a_h1, a_h0, a_m1, a_m0, a_s1, a_s0};
  assign obs12 = {b_ro, b_h1, b_h0, b_m1, b_m0, b_s1, b_s0};

  function automatic logic [24:0] pack(input int h, input int m, input int s, input bit ro);
    return {ro, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [24:0] model_vec(input int md);
    return pack(mh[md], mm[md], ms[md], mro[md]);
  endfunction

  function automatic int next_hour(input int md, input int h);
    if (md == 0) return (h + 1) % 24;
    return (h == 12) ? 1 : h + 1;
  endfunction

  // Drive one clock of stimulus, then advance the reference model for both modes.
  task automatic cycle(input bit rst, input bit en, input bit tick,
                       input bit ah, input bit am, input bit as_);
    reset = rst; clk_en = en; sec_tick = tick;
    adj_hrs = ah; adj_min = am; adj_sec = as_;
    @(posedge clk);
    #1;
    for (int md = 0; md < 2; md++) begin
      mro[md] = 1'b0;
      if (rst) begin
        mh[md] = (md == 0) ? 0 : 12;
        mm[md] = 0;
        ms[md] = 0;
      end else if (en) begin
        if (ah || am || as_) begin
          if (ah) mh[md] = next_hour(md, mh[md]);
          if (am) mm[md] = (mm[md] + 1) % 60;
          if (as_) ms[md] = (ms[md] + 1) % 60;
        end else if (tick) begin
          ms[md] = ms[md] + 1;
          if (ms[md] == 60) begin
            ms[md] = 0;
            mro[md] = 1'b1;
            mm[md] = mm[md] + 1;
            if (mm[md] == 60) begin
              mm[md] = 0;
              mh[md] = next_hour(md, mh[md]);
            end
          end
        end
      end
    end
    reset = 1'b0; clk_en = 1'b1; sec_tick = 1'b0;
    adj_hrs = 1'b0; adj_min = 1'b0; adj_sec = 1'b0;
  endtask

  // Reset, then walk the fields of mode md up to the target with set pulses.
  task automatic preload(input int md, input int th, input int tm, input int ts);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (mh[md] == th && mm[md] == tm && ms[md] == ts) break;
      cycle(1'b0, 1'b1, 1'b0, mh[md] != th, mm[md] != tm, ms[md] != ts);
    end
    n_checks++;
    if ((md == 0 ? obs24 : obs12) !== pack(th, tm, ts, 1'b0)) begin
      n_errors++;
      $display("FAIL preload_%0d: got %h want %h", md, (md == 0 ? obs24 : obs12), pack(th, tm, ts, 1'b0));
    end
    $display("preload mode%0d -> 24h=%h 12h=%h", md, obs24, obs12);
  endtask

  task automatic test_reset_and_minute();
    int ro_count = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs24 !== pack(0, 0, 0, 1'b0)) begin
      n_errors++; $display("FAIL reset_24h: got %h want %h", obs24, pack(0, 0, 0, 1'b0));
    end
    n_checks++;
    if (obs12 !== pack(12, 0, 0, 1'b0)) begin
      n_errors++; $display("FAIL reset_12h: got %h want %h", obs12, pack(12, 0, 0, 1'b0));
    end
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (a_ro === 1'b1) ro_count++;
      n_checks++;
      if (obs24 !== model_vec(0) || obs12 !== model_vec(1)) begin
        n_errors++;
        $display("FAIL tick_%0d: got %h/%h want %h/%h", i, obs24, obs12, model_vec(0), model_vec(1));
      end
    end
    $display("sixty ticks: 24h=%h 12h=%h rollovers=%0d", obs24, obs12, ro_count);
    n_checks++;
    if (obs24 !== pack(0, 1, 0, 1'b1)) begin
      n_errors++; $display("FAIL sixty_ticks: got %h want %h", obs24, pack(0, 1, 0, 1'b1));
    end
    n_checks++;
    if (ro_count != 1) begin
      n_errors++; $display("FAIL rollover_count: got %0d want 1", ro_count);
    end
  endtask

  task automatic test_day_wrap();
    preload(0, 23, 59, 59);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("day wrap: 24h=%h 12h=%h", obs24, obs12);
    n_checks++;
    if (obs24 !== pack(0, 0, 0, 1'b1)) begin
      n_errors++; $display("FAIL day_wrap: got %h want %h", obs24, pack(0, 0, 0, 1'b1));
    end
    n_checks++;
    if (obs12 !== pack(12, 0, 0, 1'b1)) begin
      n_errors++; $display("FAIL day_wrap_12h: got %h want %h", obs12, pack(12, 0, 0, 1'b1));
    end
  endtask

  task automatic test_12h_mode();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("12h adj_hrs: 12h=%h", obs12);
    n_checks++;
    if (obs12 !== pack(1, 0, 0, 1'b0)) begin
      n_errors++; $display("FAIL adj_hrs_12h: got %h want %h", obs12, pack(1, 0, 0, 1'b0));
    end
    preload(1, 12, 59, 59);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("12h wrap: 12h=%h", obs12);
    n_checks++;
    if (obs12 !== pack(1, 0, 0, 1'b1)) begin
      n_errors++; $display("FAIL wrap_12h: got %h want %h", obs12, pack(1, 0, 0, 1'b1));
    end
    preload(1, 11, 59, 59);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs12 !== pack(12, 0, 0, 1'b1)) begin
      n_errors++; $display("FAIL eleven_to_twelve: got %h want %h", obs12, pack(12, 0, 0, 1'b1));
    end
  endtask

  task automatic test_adj_no_carry();
    preload(0, 10, 59, 30);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("adj_min at 59: 24h=%h", obs24);
    n_checks++;
    if (obs24 !== pack(10, 0, 30, 1'b0)) begin
      n_errors++; $display("FAIL adj_min_wrap: got %h want %h", obs24, pack(10, 0, 30, 1'b0));
    end
    preload(0, 10, 20, 59);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs24 !== pack(10, 20, 0, 1'b0)) begin
      n_errors++; $display("FAIL adj_sec_wrap: got %h want %h", obs24, pack(10, 20, 0, 1'b0));
    end
  endtask

  task automatic test_adj_priority();
    preload(0, 0, 0, 5);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("adj_sec+tick: 24h=%h", obs24);
    n_checks++;
    if (obs24 !== pack(0, 0, 6, 1'b0)) begin
      n_errors++; $display("FAIL adj_priority: got %h want %h", obs24, pack(0, 0, 6, 1'b0));
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs24 !== pack(1, 1, 7, 1'b0)) begin
      n_errors++; $display("FAIL adj_all: got %h want %h", obs24, pack(1, 1, 7, 1'b0));
    end
  endtask

  task automatic test_clk_en_and_reset();
    preload(0, 10, 20, 30);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs24 !== pack(10, 20, 30, 1'b0) || obs12 !== model_vec(1)) begin
        n_errors++;
        $display("FAIL clk_en_hold_%0d: got %h/%h want %h/%h", i, obs24, obs12,
                 pack(10, 20, 30, 1'b0), model_vec(1));
      end
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("reset with tick: 24h=%h 12h=%h", obs24, obs12);
    n_checks++;
    if (obs24 !== pack(0, 0, 0, 1'b0) || obs12 !== pack(12, 0, 0, 1'b0)) begin
      n_errors++;
      $display("FAIL reset_override: got %h/%h want %h/%h", obs24, obs12,
               pack(0, 0, 0, 1'b0), pack(12, 0, 0, 1'b0));
    end
  endtask

  task automatic test_random();
    bit rst, en, tick, ah, am, as_;
    preload(0, 23, 58, 40);
    for (int i = 0; i < 700; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 3) != 0);
      tick = ($urandom_range(0, 3) != 0);
      ah   = ($urandom_range(0, 9) == 0);
      am   = ($urandom_range(0, 9) == 0);
      as_  = ($urandom_range(0, 9) == 0);
      cycle(rst, en, tick, ah, am, as_);
      $display("rand %0d in=%b%b%b%b%b%b 24h=%h 12h=%h", i, rst, en, tick, ah, am, as_, obs24, obs12);
      n_checks++;
      if (obs24 !== model_vec(0) || obs12 !== model_vec(1)) begin
        n_errors++;
        $display("FAIL random_%0d: got %h/%h want %h/%h", i, obs24, obs12, model_vec(0), model_vec(1));
      end
    end
  endtask

  initial begin
    test_reset_and_minute();
    test_day_wrap();
    test_12h_mode();
    test_adj_no_carry();
    test_adj_priority();
    test_clk_en_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
